// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write port, packed read ports, scoreboard issue/flush and status.
// Parameters must match the regfile_sb instance the bundle is bound to.
interface regfile_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                  write_ctrl;
  logic [AW-1:0]         write_addr;
  logic [XLEN-1:0]       write_data;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  issue_ctrl;
  logic [AW-1:0]         issue_addr;
  logic                  flush;
  logic [AW:0]           busy_count;

  // Issue/pipeline side drives requests and observes reads and scoreboard state.
  modport master (
    output write_ctrl, write_addr, write_data, rd_addr, issue_ctrl, issue_addr, flush,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  write_ctrl, write_addr, write_data, rd_addr, issue_ctrl, issue_addr, flush,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with hardwired-zero x0, NREAD combinational read ports and a pending-write scoreboard.
// Optional write-first forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_sb_if.slave   bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [CW-1:0]    busy_count_q;
  logic [CW-1:0]    busy_count_d;
  logic             wr_en;

  assign wr_en = bus.write_ctrl && (bus.write_addr != '0);

  // Register storage; entry 0 is only ever cleared, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.write_addr] <= bus.write_data;
    end
  end

  // Scoreboard next state: a new reservation beats flush, which beats write-back.
  always_comb begin
    busy_d       = busy_q;
    busy_count_d = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (bus.issue_ctrl && (bus.issue_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (bus.flush) begin
        busy_d[i] = 1'b0;
      end else if (bus.write_ctrl && (bus.write_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_count_d = busy_count_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign bus.busy_count = busy_count_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = bus.rd_addr[k*AW +: AW];

    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
      // Same-cycle write-back retires the pending write unless it is re-reserved this cycle.
      if (rst_n && bus.write_ctrl && (bus.write_addr == addr) && (addr != '0)) begin
        data = bus.write_data;
        busy = bus.issue_ctrl && (bus.issue_addr == addr);
      end
`endif
    end

    assign bus.rd_data[k*XLEN +: XLEN] = data;
    assign bus.rd_busy[k]              = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_sb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NREAD = 2;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              tests = 0;
  int              fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input int wa, input logic [31:0] wd,
                       input bit is, input int ia, input bit fl, input int r0, input int r1);
    bus.write_ctrl = w;
    bus.write_addr = AW'(wa);
    bus.write_data = wd;
    bus.issue_ctrl = is;
    bus.issue_addr = AW'(ia);
    bus.flush      = fl;
    bus.rd_addr    = {AW'(r1), AW'(r0)};
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Apply the architectural rules of one rising edge to the model.
  task automatic model_edge();
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int i = 1; i < NREGS; i++) begin
      if (bus.issue_ctrl && int'(bus.issue_addr) == i) m_busy[i] = 1'b1;
      else if (bus.flush)                              m_busy[i] = 1'b0;
      else if (bus.write_ctrl && int'(bus.write_addr) == i) m_busy[i] = 1'b0;
    end
    if (bus.write_ctrl && bus.write_addr != 0) m_regs[bus.write_addr] = bus.write_data;
  endtask

  task automatic check_outputs(input string tag);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] ed;
    logic            eb;
    for (int k = 0; k < NREAD; k++) begin
      a  = bus.rd_addr[k*AW +: AW];
      ed = m_regs[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && bus.write_ctrl && bus.write_addr == a && a != 0) begin
        ed = bus.write_data;
        eb = bus.issue_ctrl && bus.issue_addr == a;
      end
`endif
      chk($sformatf("%s_data%0d", tag, k), 64'(bus.rd_data[k*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("%s_busy%0d", tag, k), 64'(bus.rd_busy[k]), 64'(eb));
    end
    chk($sformatf("%s_count", tag), 64'(bus.busy_count), 64'(model_count()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_outputs(tag);
    tick();
  endtask

  initial begin
    logic [31:0] exp_byp;
    rst_n = 1'b0;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    // Reset held: every address reads zero on both ports.
    for (int a = 0; a < NREGS; a++) begin
      drive(0, 0, 0, 0, 0, 0, a, NREGS - 1 - a);
      #1;
      chk($sformatf("rst_data_a%0d", a), 64'(bus.rd_data), 64'(0));
      chk($sformatf("rst_busy_a%0d", a), 64'(bus.rd_busy), 64'(0));
    end
    chk("rst_count", 64'(bus.busy_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // x3 write and ignored x0 write.
    drive(1, 3, 32'h1234_5678, 0, 0, 0, 3, 0); cycle("wr_x3");
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 3, 0); cycle("wr_x0");
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clk);
    check_outputs("rd_x3_x0");
    chk("x3_value", 64'(bus.rd_data[31:0]), 64'h1234_5678);
    chk("x0_value", 64'(bus.rd_data[63:32]), 64'h0);
    tick();

    // Reserve x7 then x9, then retire x7 by write-back.
    drive(0, 0, 0, 1, 7, 0, 7, 9); cycle("iss_x7");
    drive(0, 0, 0, 1, 9, 0, 7, 9);
    @(negedge clk);
    chk("count_after_x7", 64'(bus.busy_count), 64'd1);
    check_outputs("iss_x9");
    tick();
    drive(0, 0, 0, 0, 0, 0, 7, 9);
    @(negedge clk);
    chk("count_x7_x9", 64'(bus.busy_count), 64'd2);
    chk("busy_x7_x9", 64'(bus.rd_busy), 64'b11);
    tick();
    drive(1, 7, 32'hA5, 0, 0, 0, 7, 9); cycle("wb_x7");
    drive(0, 0, 0, 0, 0, 0, 7, 9);
    @(negedge clk);
    check_outputs("after_wb_x7");
    chk("count_after_wb", 64'(bus.busy_count), 64'd1);
    chk("busy_after_wb", 64'(bus.rd_busy), 64'b10);
    chk("x7_value", 64'(bus.rd_data[31:0]), 64'hA5);
    tick();

    // Issue beats a simultaneous write to the same register.
    drive(1, 4, 32'h55, 1, 4, 0, 4, 4); cycle("iss_wr_x4");
    drive(0, 0, 0, 0, 0, 0, 4, 4);
    @(negedge clk);
    chk("x4_value", 64'(bus.rd_data[31:0]), 64'h55);
    chk("x4_busy", 64'(bus.rd_busy[0]), 64'd1);
    tick();
    // Issue beats a simultaneous flush; other reservations are dropped.
    drive(0, 0, 0, 1, 8, 0, 6, 8); cycle("iss_x8");
    drive(0, 0, 0, 1, 6, 1, 6, 8); cycle("iss_x6_flush");
    drive(0, 0, 0, 0, 0, 0, 6, 8);
    @(negedge clk);
    chk("busy_x6_x8", 64'(bus.rd_busy), 64'b01);
    chk("count_after_flush", 64'(bus.busy_count), 64'd1);
    tick();

    // Reserving x0 never sets busy.
    drive(0, 0, 0, 0, 0, 1, 0, 0); cycle("flush_all");
    drive(0, 0, 0, 1, 0, 0, 0, 0); cycle("iss_x0");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("count_iss_x0", 64'(bus.busy_count), 64'd0);
    chk("busy_x0", 64'(bus.rd_busy), 64'b00);
    tick();

    // Same-cycle read of a register being written.
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hCAFE;
`else
    exp_byp = 32'h0;
`endif
    drive(1, 10, 32'hCAFE, 0, 0, 0, 10, 10);
    @(negedge clk);
    chk("x10_same_cycle", 64'(bus.rd_data[31:0]), 64'(exp_byp));
    chk("x10_same_busy", 64'(bus.rd_busy[0]), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 10, 10);
    @(negedge clk);
    chk("x10_next_cycle", 64'(bus.rd_data[31:0]), 64'hCAFE);
    tick();

    // Mid-run reset discards data and reservations immediately.
    drive(1, 5, 32'hDEAD_BEEF, 1, 12, 0, 5, 12); cycle("wr_x5");
    drive(0, 0, 0, 0, 0, 0, 5, 12);
    @(negedge clk);
    chk("x5_before_rst", 64'(bus.rd_data[31:0]), 64'hDEAD_BEEF);
    chk("x12_busy_before_rst", 64'(bus.rd_busy[1]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("x5_in_rst", 64'(bus.rd_data[31:0]), 64'h0);
    chk("busy_in_rst", 64'(bus.rd_busy), 64'h0);
    chk("count_in_rst", 64'(bus.busy_count), 64'h0);
    model_clear();
    drive(1, 5, 32'h1111, 1, 5, 0, 5, 12);
    tick();
    #1;
    chk("x5_rst_held", 64'(bus.rd_data[31:0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5, 12);
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 12); cycle("after_rst");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)), $urandom,
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, NREGS - 1)),
            ($urandom_range(0, 15) == 0),
            int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)));
      cycle($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the single-cycle/early-pipelined RISC-V core.
- Provides NREAD combinational read ports, one synchronous write port, hardwired-zero x0, and asynchronous clear of all registers.
- Includes a per-register pending-write scoreboard (busy bits plus pending counter) so a multi-cycle unit (load/divide) can reserve a destination and the issue logic can detect RAW hazards.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, 2..64.
- AW, $clog2(NREGS), address width; derived, not overridden.
- NREAD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- write_ctrl  in  1  write enable, sampled on the rising edge.
- write_addr  in  AW  destination register of the write.
- write_data  in  XLEN  write data.
- rd_addr  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NREAD*XLEN  packed read data.
- rd_busy  out  NREAD  per-port flag: the addressed register has a pending write.
- issue_ctrl  in  1  reserve issue_addr as a pending destination.
- issue_addr  in  AW  register being reserved.
- flush  in  1  synchronous clear of all busy bits (pipeline kill).
- busy_count  out  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers go to 0, all busy bits to 0, busy_count to 0.
  - rd_data reads 0 and rd_busy reads 0 while reset is held.
  - Deassertion takes effect at the next rising edge.
  - Reset in the middle of any sequence discards all pending reservations.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are ignored.
  - Issue to address 0 never sets busy; busy[0] is constant 0.
- Write:
  - If write_ctrl is high at a rising edge, regs[write_addr] <= write_data (write_addr != 0).
  - Without bypass, the new value is visible on rd_data the cycle after the edge.
- Read: rd_data[k] = regs[rd_addr[k]], combinational, with no registered latency.
- Scoreboard, per register i != 0, evaluated at each rising edge, in priority order:
  1. issue_ctrl && issue_addr==i → busy[i] <= 1. Issue wins over a simultaneous write or flush to the same register, because the newer reservation supersedes.
  2. else if flush → busy[i] <= 0.
  3. else if write_ctrl && write_addr==i → busy[i] <= 0.
  4. else hold.
- Writes to a non-busy register are legal and leave busy at 0.
- Re-issue to an already-busy register keeps it at 1; there is no nesting count.
- rd_busy[k] = busy[rd_addr[k]], unless the bypass rule below applies.
- busy_count:
  - Registered; equals the population count of the busy vector after each edge.
  - Updated in the same edge as busy, so it is never stale relative to busy.
  - Range 0..NREGS-1; no overflow is possible.
- No handshake back-pressure. The write port always accepts, and issue always accepts.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When write_ctrl && write_addr==rd_addr[k] && rd_addr[k]!=0, rd_data[k] = write_data in the same cycle (write-first forwarding).
  - rd_busy[k] = 0 for that port in that cycle, unless issue_ctrl targets the same address in the same cycle.
  - Forwarding is suppressed while rst_n is low.
- Undefined:
  - Reads return stored contents only; the same-cycle write is not visible.
  - rd_busy reflects the registered busy bit only.

Test Plan:
- Reset then read all ports at every address → rd_data=0, rd_busy=0, busy_count=0; assert rst_n low mid-run after writing x5=0xDEADBEEF → x5 reads 0 immediately.
- Write x3=0x12345678 and x0=0xFFFFFFFF, then read port0=x3, port1=x0 → 0x12345678 and 0.
- Issue x7 and x9 in consecutive cycles → busy_count 1 then 2, rd_busy set for x7/x9. Then write x7=0xA5 → busy_count=1 and rd_busy(x7)=0 on the next cycle.
- Same edge: issue x4 and write x4=0x55 → x4 reads 0x55 and busy(x4) stays 1. Same edge: issue x6 plus flush with x8 busy → busy(x6)=1, busy(x8)=0, busy_count=1.
- Issue x0 → busy_count stays 0.
- With REGFILE_BYPASS_EN: write x10=0xCAFE while port0 reads x10 in the same cycle → rd_data=0xCAFE, rd_busy=0. Without the macro → old value 0 is returned that cycle and 0xCAFE the next.
